// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status bit positions and the arbiter FSM encoding.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract with NZCV flags; subtract is a + ~b + 1 on one carry chain.
module addsub_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  assign bx     = (op == OP_SUB) ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op};
  assign result = sum[WIDTH-1:0];

  // Overflow tested against the inverted operand covers both add and subtract.
  always_comb begin
    status       = '0;
    status[ST_N] = result[WIDTH-1];
    status[ST_Z] = (result == '0);
    status[ST_C] = sum[WIDTH];
    status[ST_V] = (a[WIDTH-1] == bx[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Arbitrates NREQ requesters onto one add/subtract core; IDLE -> CALC -> RESP per transaction.
// Define ADDSUB_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module addsub_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_op,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [WIDTH-1:0]           resp_result,
  output logic [3:0]                 resp_status
);

  localparam int IDW = $clog2(NREQ);

  logic [1:0]       state;
  logic [IDW-1:0]   gnt;
  logic             hit;
  logic [WIDTH-1:0] a_q, b_q, core_res;
  logic             op_q;
  logic [IDW-1:0]   id_q;
  logic [3:0]       core_st;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt = IDW'(i);
        hit = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] last;
  logic [IDW-1:0] idx;

  // Walk from farthest to nearest after last so the nearest valid requester wins.
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= IDW'(NREQ - 1);
    else if (state == S_IDLE && hit)
      last <= gnt;
  end
`endif

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && hit)
      req_ready[gnt] = 1'b1;
  end

  assign resp_valid = (state == S_RESP);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_res),
    .status (core_st)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_status <= '0;
    end else begin
      case (state)
        S_IDLE: if (hit) begin
          a_q   <= req_a[int'(gnt)*WIDTH +: WIDTH];
          b_q   <= req_b[int'(gnt)*WIDTH +: WIDTH];
          op_q  <= req_op[gnt];
          id_q  <= gnt;
          state <= S_CALC;
        end
        S_CALC: begin
          resp_id     <= id_q;
          resp_result <= core_res;
          resp_status <= core_st;
          state       <= S_RESP;
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (WIDTH=8, NREQ=4) with a transaction-level reference model.
module tb_addsub_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_result;
  logic [3:0]     resp_status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_status (resp_status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int winner(input logic [N-1:0] v, input int last);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++)
      if (v[i]) return i + 0 * last;
`else
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic void calc(input logic op, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] r, output logic [3:0] st);
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      u = ua - ub;
      s = sa - sb;
      st[1] = (ua >= ub);
    end else begin
      u = ua + ub;
      s = sa + sb;
      st[1] = (u > 255);
    end
    r     = u[7:0];
    st[3] = r[7];
    st[2] = (r == 8'h00);
    st[0] = (s > 127) || (s < -128);
  endfunction

  int         m_ph = 0;      // 0 waiting for grant, 1 computing, 2 response pending
  int         m_last = N - 1;
  int         m_w, wi;
  int         p_id = 0;
  logic [7:0] p_res = '0, c_res;
  logic [3:0] p_st = '0, c_st;
  int         e_id = 0;
  logic [7:0] e_res = '0;
  logic [3:0] e_st = '0;
  logic [3:0] e_rdy;

  always_comb begin
    m_w = winner(req_valid, m_last);
    wi  = (m_w < 0) ? 0 : m_w;
    calc(req_op[wi], req_a[wi*W +: W], req_b[wi*W +: W], c_res, c_st);
    e_rdy = (m_ph == 0 && m_w >= 0) ? 4'(1 << m_w) : 4'b0000;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_last <= N - 1;
      e_id <= 0; e_res <= '0; e_st <= '0;
    end else begin
      case (m_ph)
        0: if (m_w >= 0) begin
          m_ph <= 1; m_last <= m_w;
          p_id <= m_w; p_res <= c_res; p_st <= c_st;
        end
        1: begin
          m_ph <= 2; e_id <= p_id; e_res <= p_res; e_st <= p_st;
        end
        default: if (resp_ready) m_ph <= 0;
      endcase
    end
  end

  logic r1_mon = 1'b0, r1_seen = 1'b0;

  always @(negedge clk) begin
    chk("req_ready",   32'(req_ready),   32'(e_rdy));
    chk("resp_valid",  32'(resp_valid),  32'(m_ph == 2));
    chk("resp_id",     32'(resp_id),     32'(e_id));
    chk("resp_result", 32'(resp_result), 32'(e_res));
    chk("resp_status", 32'(resp_status), 32'(e_st));
    if (r1_mon && req_ready[1]) r1_seen <= 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_resp(input string name);
    int c = 0;
    @(negedge clk);
    while (!resp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(resp_valid), 32'd1);
  endtask

  task automatic do_one(input int i, input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic [3:0] st);
    req_valid[i] = 1'b1; req_op[i] = op;
    req_a[i*W +: W] = a; req_b[i*W +: W] = b;
    @(negedge clk);
    chk("one_grant", 32'(req_ready), 32'(1 << i));
    step();
    req_valid[i] = 1'b0;
    step();
    @(negedge clk);
    chk("one_valid",  32'(resp_valid),  32'd1);
    chk("one_id",     32'(resp_id),     32'(i));
    chk("one_result", 32'(resp_result), 32'(r));
    chk("one_status", 32'(resp_status), 32'(st));
    step();
  endtask

  initial begin
    int got[$];
    int exp_seq[5];
    int c;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready",  32'(req_ready),   32'd0);
    chk("rst_valid",  32'(resp_valid),  32'd0);
    chk("rst_id",     32'(resp_id),     32'd0);
    chk("rst_result", 32'(resp_result), 32'd0);
    chk("rst_status", 32'(resp_status), 32'd0);
    step();
    rst = 1'b0;

    do_one(2, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1001);
    do_one(0, 1'b1, 8'h00, 8'h01, 8'hFF, 4'b1000);
    do_one(0, 1'b1, 8'h05, 8'h05, 8'h00, 4'b0110);
    do_one(1, 1'b1, 8'h80, 8'h01, 8'h7F, 4'b0011);
    do_one(3, 1'b1, 8'h7F, 8'h80, 8'hFF, 4'b1001);
    do_one(2, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0110);
    do_one(1, 1'b1, 8'h05, 8'h00, 8'h05, 4'b0010);

    // all requesters valid continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_op[i] = i[0];
      req_a[i*W +: W] = 8'(8'h10 + i);
      req_b[i*W +: W] = 8'(i + 1);
    end
    req_valid = '1;
    c = 0;
    while (got.size() < 5 && c < 60) begin
      @(negedge clk);
      if (resp_valid && resp_ready) got.push_back(int'(resp_id));
      c++;
    end
    step();
    req_valid = '0;
    chk("rr_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk("rr_order", 32'(got[k]), 32'(exp_seq[k]));

    // backpressure
    resp_ready = 1'b0;
    req_op[1] = 1'b0; req_a[1*W +: W] = 8'h10; req_b[1*W +: W] = 8'h20;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid[1] = 1'b0;
    wait_resp("bp_wait");
    step();
    req_op[3] = 1'b0; req_a[3*W +: W] = 8'h01; req_b[3*W +: W] = 8'h01;
    req_valid[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready",  32'(req_ready),   32'd0);
      chk("bp_result", 32'(resp_result), 32'h30);
      chk("bp_id",     32'(resp_id),     32'd1);
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid[3] = 1'b0;
    wait_resp("bp_wait2");
    chk("bp_result2", 32'(resp_result), 32'h02);
    step();

    // reset during CALC
    req_op[2] = 1'b0; req_a[2*W +: W] = 8'h03; req_b[2*W +: W] = 8'h04;
    req_valid[2] = 1'b1;
    step();
    req_valid[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid",  32'(resp_valid),  32'd0);
    chk("mid_rst_result", 32'(resp_result), 32'd0);
    chk("mid_rst_ready",  32'(req_ready),   32'd0);
    step();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(resp_valid), 32'd0);
      step();
    end
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk);
    chk("post_rst_first", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_resp("post_rst_wait");
    chk("post_rst_id", 32'(resp_id), 32'd0);
    step();

    // requester 1 withdraws before it can be granted
    req_op[0] = 1'b1; req_a[0 +: W] = 8'h09; req_b[0 +: W] = 8'h03;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    resp_ready = 1'b0;
    r1_mon = 1'b1;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("drop_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid[3] = 1'b0;
    wait_resp("drop_wait");
    chk("drop_id", 32'(resp_id), 32'd3);
    step();
    @(negedge clk);
    r1_mon = 1'b0;
    chk("drop_r1_never", 32'(r1_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
